// File: rtl/ycr_pipe_wb_arb_pkg.sv
// Shared types and default sizing for the write-back arbiter and its FIFOs.
// Register-file widths default here when the core headers have not set them.
`ifndef YCR_XLEN
`define YCR_XLEN 32
`endif
`ifndef YCR_MPRF_AWIDTH
`define YCR_MPRF_AWIDTH 5
`endif

package ycr_pipe_wb_arb_pkg;

  localparam int YCR_WB_LD_OUTST   = 2;
  localparam int YCR_WB_BUF_DEPTH  = 2;

  typedef struct packed {
    logic [`YCR_MPRF_AWIDTH-1:0] addr;
    logic [`YCR_XLEN-1:0]        data;
  } ycr_wb_entry_s;

endpackage

// File: rtl/ycr_wb_fifo.sv
// Small synchronous FIFO with extra-bit wrap pointers; DEPTH must be a power of 2 and >= 2.
// A push while full is accepted only when a pop happens in the same cycle.
module ycr_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ycr_pipe_wb_arb.sv
// Write-back arbiter: merges ALU results and buffered load returns onto the MPRF
// write port, and keeps a scoreboard of registers with loads still in flight.
module ycr_pipe_wb_arb
  import ycr_pipe_wb_arb_pkg::*;
#(
  parameter int LD_OUTST     = YCR_WB_LD_OUTST,
  parameter int WB_BUF_DEPTH = YCR_WB_BUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu2wb_req_i,
  input  logic [`YCR_MPRF_AWIDTH-1:0] alu2wb_rd_addr_i,
  input  logic [`YCR_XLEN-1:0]        alu2wb_rd_data_i,
  input  logic                        lsu2wb_ld_issue_i,
  input  logic [`YCR_MPRF_AWIDTH-1:0] lsu2wb_ld_rd_i,
  output logic                        wb2lsu_issue_rdy_o,
  input  logic                        lsu2wb_ld_vd_i,
  input  logic [`YCR_XLEN-1:0]        lsu2wb_ld_data_i,
  output logic                        wb2lsu_ld_rdy_o,
  input  logic [`YCR_MPRF_AWIDTH-1:0] exu2wb_rs1_addr_i,
  input  logic [`YCR_MPRF_AWIDTH-1:0] exu2wb_rs2_addr_i,
  input  logic [`YCR_MPRF_AWIDTH-1:0] exu2wb_rd_addr_i,
  output logic                        wb2exu_hazard_o,
  output logic                        exu2mprf_w_req_o,
  output logic [`YCR_MPRF_AWIDTH-1:0] exu2mprf_rd_addr_o,
  output logic [`YCR_XLEN-1:0]        exu2mprf_rd_data_o,
  output logic                        wb_err_o
);

  localparam int NREG = 1 << `YCR_MPRF_AWIDTH;

  logic                        ldq_full, ldq_empty;
  logic [`YCR_MPRF_AWIDTH-1:0] ldq_head;
  logic                        buf_full, buf_empty, buf_pop;
  ycr_wb_entry_s               buf_head, buf_push_entry;
  logic                        issue_push, ret_hs, ret_ok, ret_orphan;
  logic [NREG-1:0]             sb_q, sb_d;
  logic                        err_q, err_d;
  logic                        sel_vld;
  logic [`YCR_MPRF_AWIDTH-1:0] sel_addr;
  logic [`YCR_XLEN-1:0]        sel_data;

  assign issue_push = lsu2wb_ld_issue_i && !ldq_full;
  assign ret_hs     = lsu2wb_ld_vd_i && !buf_full;
  assign ret_ok     = ret_hs && !ldq_empty;
  assign ret_orphan = ret_hs && ldq_empty;

  assign buf_push_entry.addr = ldq_head;
  assign buf_push_entry.data = lsu2wb_ld_data_i;

  // rd==0 loads still occupy a slot so that returns stay matched in issue order.
  ycr_wb_fifo #(
    .WIDTH (`YCR_MPRF_AWIDTH),
    .DEPTH (LD_OUTST)
  ) i_ld_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue_push),
    .data_i  (lsu2wb_ld_rd_i),
    .pop_i   (ret_ok),
    .data_o  (ldq_head),
    .full_o  (ldq_full),
    .empty_o (ldq_empty)
  );

  ycr_wb_fifo #(
    .WIDTH ($bits(ycr_wb_entry_s)),
    .DEPTH (WB_BUF_DEPTH)
  ) i_wb_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ret_ok),
    .data_i  (buf_push_entry),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // ALU results always win the port; buffered loads drain in the gaps.
  always_comb begin
    sel_vld  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    buf_pop  = 1'b0;
    if (alu2wb_req_i) begin
      sel_vld  = 1'b1;
      sel_addr = alu2wb_rd_addr_i;
      sel_data = alu2wb_rd_data_i;
    end else if (!buf_empty) begin
      sel_vld  = 1'b1;
      sel_addr = buf_head.addr;
      sel_data = buf_head.data;
      buf_pop  = 1'b1;
    end
  end

  assign exu2mprf_w_req_o   = sel_vld && (sel_addr != '0);
  assign exu2mprf_rd_addr_o = sel_addr;
  assign exu2mprf_rd_data_o = sel_data;

  // Set is applied after clear so a same-cycle set on the same bit wins.
  always_comb begin
    sb_d = sb_q;
    if (buf_pop && (buf_head.addr != '0)) sb_d[buf_head.addr] = 1'b0;
    if (issue_push && (lsu2wb_ld_rd_i != '0)) sb_d[lsu2wb_ld_rd_i] = 1'b1;
    err_d = err_q | ret_orphan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      err_q <= err_d;
    end
  end

  assign wb2exu_hazard_o = (sb_q[exu2wb_rs1_addr_i] && (exu2wb_rs1_addr_i != '0)) ||
                           (sb_q[exu2wb_rs2_addr_i] && (exu2wb_rs2_addr_i != '0)) ||
                           (sb_q[exu2wb_rd_addr_i]  && (exu2wb_rd_addr_i  != '0));

  assign wb2lsu_issue_rdy_o = !ldq_full;
  assign wb2lsu_ld_rdy_o    = !buf_full;
  assign wb_err_o           = err_q;

endmodule

// File: tb/tb_ycr_pipe_wb_arb.sv
// Bench for the write-back arbiter: queue-based model of pending loads and buffered
// returns, directed scenarios with literal expectations, then a randomized run.
module tb_ycr_pipe_wb_arb;
  import ycr_pipe_wb_arb_pkg::*;

  localparam int AW   = `YCR_MPRF_AWIDTH;
  localparam int XW   = `YCR_XLEN;
  localparam int LDN  = 2;
  localparam int BUFN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aluReq = 1'b0;
  logic [AW-1:0] aluRd = '0;
  logic [XW-1:0] aluData = '0;
  logic          ldIssue = 1'b0;
  logic [AW-1:0] ldRd = '0;
  logic          issueRdy;
  logic          ldVd = 1'b0;
  logic [XW-1:0] ldData = '0;
  logic          ldRdy;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rdDec = '0;
  logic          hazard, wReq, wbErr;
  logic [AW-1:0] wAddr;
  logic [XW-1:0] wData;

  always #5 clk = ~clk;

  ycr_pipe_wb_arb #(.LD_OUTST(LDN), .WB_BUF_DEPTH(BUFN)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu2wb_req_i       (aluReq),
    .alu2wb_rd_addr_i   (aluRd),
    .alu2wb_rd_data_i   (aluData),
    .lsu2wb_ld_issue_i  (ldIssue),
    .lsu2wb_ld_rd_i     (ldRd),
    .wb2lsu_issue_rdy_o (issueRdy),
    .lsu2wb_ld_vd_i     (ldVd),
    .lsu2wb_ld_data_i   (ldData),
    .wb2lsu_ld_rdy_o    (ldRdy),
    .exu2wb_rs1_addr_i  (rs1),
    .exu2wb_rs2_addr_i  (rs2),
    .exu2wb_rd_addr_i   (rdDec),
    .wb2exu_hazard_o    (hazard),
    .exu2mprf_w_req_o   (wReq),
    .exu2mprf_rd_addr_o (wAddr),
    .exu2mprf_rd_data_o (wData),
    .wb_err_o           (wbErr)
  );

  int nChecks = 0;
  int nFails  = 0;

  // Model state: loads issued but not returned, and returns not yet written.
  logic [AW-1:0] mLdq[$];
  ycr_wb_entry_s mBuf[$];
  bit            mErr = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit isPending(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    foreach (mLdq[i]) if (mLdq[i] == r) return 1'b1;
    foreach (mBuf[i]) if (mBuf[i].addr == r) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, compare every output against the model, then advance the model.
  task automatic applyStimulus(input bit aReq, input logic [AW-1:0] aRd, input logic [XW-1:0] aData,
                               input bit iss, input logic [AW-1:0] issRd,
                               input bit vd, input logic [XW-1:0] vData,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic [AW-1:0] rdd);
    bit            sel, doPop, expReq, expHaz, expIssRdy, expLdRdy;
    logic [AW-1:0] expAddr;
    logic [XW-1:0] expData;
    ycr_wb_entry_s e;
    @(posedge clk);
    #1;
    aluReq = aReq; aluRd = aRd; aluData = aData;
    ldIssue = iss; ldRd = issRd;
    ldVd = vd; ldData = vData;
    rs1 = r1; rs2 = r2; rdDec = rdd;
    #1;
    expIssRdy = (mLdq.size() < LDN);
    expLdRdy  = (mBuf.size() < BUFN);
    sel = 1'b0; doPop = 1'b0; expAddr = '0; expData = '0;
    if (aReq) begin
      sel = 1'b1; expAddr = aRd; expData = aData;
    end else if (mBuf.size() > 0) begin
      sel = 1'b1; expAddr = mBuf[0].addr; expData = mBuf[0].data; doPop = 1'b1;
    end
    expReq = sel && (expAddr != '0);
    expHaz = isPending(r1) || isPending(r2) || isPending(rdd);
    checkOutput("w_req", 64'(wReq), 64'(expReq));
    checkOutput("w_addr", 64'(wAddr), 64'(expAddr));
    if (expReq || !sel) checkOutput("w_data", 64'(wData), 64'(expData));
    checkOutput("issue_rdy", 64'(issueRdy), 64'(expIssRdy));
    checkOutput("ld_rdy", 64'(ldRdy), 64'(expLdRdy));
    checkOutput("hazard", 64'(hazard), 64'(expHaz));
    checkOutput("wb_err", 64'(wbErr), 64'(mErr));
    if (doPop) void'(mBuf.pop_front());
    if (vd && expLdRdy) begin
      if (mLdq.size() == 0) mErr = 1'b1;
      else begin
        e.addr = mLdq.pop_front();
        e.data = vData;
        mBuf.push_back(e);
      end
    end
    if (iss && expIssRdy) mLdq.push_back(issRd);
  endtask

  task automatic idle(input logic [AW-1:0] r1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, r1, 0, 0);
  endtask

  // Reset is applied mid-cycle to exercise the asynchronous path.
  task automatic doReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    aluReq = 0; aluRd = 0; aluData = 0; ldIssue = 0; ldRd = 0;
    ldVd = 0; ldData = 0; rs1 = 0; rs2 = 0; rdDec = 0;
    mLdq.delete(); mBuf.delete(); mErr = 1'b0;
    #1;
    checkOutput("rst_w_req", 64'(wReq), 64'd0);
    checkOutput("rst_w_addr", 64'(wAddr), 64'd0);
    checkOutput("rst_w_data", 64'(wData), 64'd0);
    checkOutput("rst_issue_rdy", 64'(issueRdy), 64'd1);
    checkOutput("rst_ld_rdy", 64'(ldRdy), 64'd1);
    checkOutput("rst_hazard", 64'(hazard), 64'd0);
    checkOutput("rst_wb_err", 64'(wbErr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] pickFree();
    logic [AW-1:0] r;
    for (int k = 0; k < 16; k++) begin
      r = AW'($urandom_range(1, (1 << AW) - 1));
      if (!isPending(r)) return r;
    end
    return '0;
  endfunction

  initial begin
    bit            rA, rI, rV;
    logic [AW-1:0] rRd, rIRd, r1;

    doReset();

    // ALU write goes straight through
    applyStimulus(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lit_alu_req", 64'(wReq), 64'd1);
    checkOutput("lit_alu_addr", 64'(wAddr), 64'd5);
    checkOutput("lit_alu_data", 64'(wData), 64'h1234);

    // Single load to x7
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 7, 0, 0);
    checkOutput("lit_haz_pre", 64'(hazard), 64'd0);
    idle(7);
    checkOutput("lit_haz_set", 64'(hazard), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD, 7, 0, 0);
    checkOutput("lit_ret_nowr", 64'(wReq), 64'd0);
    idle(7);
    checkOutput("lit_ld_addr", 64'(wAddr), 64'd7);
    checkOutput("lit_ld_data", 64'(wData), 64'hDEAD);
    checkOutput("lit_haz_wr", 64'(hazard), 64'd1);
    idle(7);
    checkOutput("lit_haz_clr", 64'(hazard), 64'd0);

    // Return collides with three ALU writes
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 7, 0, 0);
    applyStimulus(1, 3, 32'h33, 0, 0, 1, 32'hBEEF, 7, 0, 0);
    applyStimulus(1, 3, 32'h34, 0, 0, 0, 0, 7, 0, 0);
    applyStimulus(1, 3, 32'h35, 0, 0, 0, 0, 7, 0, 0);
    checkOutput("lit_col_alu", 64'(wAddr), 64'd3);
    idle(7);
    checkOutput("lit_col_addr", 64'(wAddr), 64'd7);
    checkOutput("lit_col_data", 64'(wData), 64'hBEEF);
    checkOutput("lit_col_haz", 64'(hazard), 64'd1);
    idle(7);
    checkOutput("lit_col_clr", 64'(hazard), 64'd0);

    // Two loads fill the load-rd FIFO; a third is dropped
    applyStimulus(0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 10, 0, 0, 10, 0, 0);
    checkOutput("lit_full", 64'(issueRdy), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hA, 10, 0, 0);
    checkOutput("lit_drop_haz", 64'(hazard), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hB, 0, 0, 0);
    checkOutput("lit_ord_a_addr", 64'(wAddr), 64'd8);
    checkOutput("lit_ord_a_data", 64'(wData), 64'hA);
    checkOutput("lit_rdy_back", 64'(issueRdy), 64'd1);
    idle(0);
    checkOutput("lit_ord_b_addr", 64'(wAddr), 64'd9);
    checkOutput("lit_ord_b_data", 64'(wData), 64'hB);

    // Load to x0 never writes and never stalls
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h55, 0, 0, 0);
    idle(0);
    checkOutput("lit_x0_req", 64'(wReq), 64'd0);

    // Orphan return sets a sticky error
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h99, 0, 0, 0);
    idle(0);
    checkOutput("lit_err_set", 64'(wbErr), 64'd1);
    checkOutput("lit_err_nowr", 64'(wReq), 64'd0);
    idle(0);
    checkOutput("lit_err_hold", 64'(wbErr), 64'd1);
    doReset();

    // Reset with a load in flight: its late return is an error
    applyStimulus(0, 0, 0, 1, 12, 0, 0, 0, 0, 0);
    idle(12);
    checkOutput("lit_mid_haz", 64'(hazard), 64'd1);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h77, 12, 0, 0);
    idle(12);
    checkOutput("lit_late_err", 64'(wbErr), 64'd1);
    checkOutput("lit_late_haz", 64'(hazard), 64'd0);
    doReset();

    // Randomized traffic within the EXU/LSU usage rules
    for (int n = 0; n < 1500; n++) begin
      if (n == 750) doReset();
      rA  = ($urandom_range(0, 1) == 1);
      rRd = ($urandom_range(0, 9) == 0) ? '0 : pickFree();
      rI  = ($urandom_range(0, 9) < 3);
      rIRd = ($urandom_range(0, 9) == 0) ? '0 : pickFree();
      if (rA && rIRd != '0 && rIRd == rRd) rI = 1'b0;
      rV  = (mLdq.size() > 0) && (mBuf.size() < BUFN) && ($urandom_range(0, 9) < 4);
      if (mLdq.size() > 0 && $urandom_range(0, 1) == 1) r1 = mLdq[0];
      else if (mBuf.size() > 0 && $urandom_range(0, 1) == 1) r1 = mBuf[0].addr;
      else r1 = AW'($urandom_range(0, (1 << AW) - 1));
      applyStimulus(rA, rRd, $urandom, rI, rIRd, rV, $urandom, r1,
                    AW'($urandom_range(0, (1 << AW) - 1)), AW'($urandom_range(0, (1 << AW) - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ycr_pipe_wb_arb.md
Name: ycr_pipe_wb_arb

Overview:
- Write-back arbiter and load scoreboard sitting directly upstream of the MPRF write port.
- Merges single-cycle ALU/CSR results and late-returning LSU load data onto the one MPRF write port.
- Buffers load returns that collide with ALU writes.
- Tracks registers with outstanding loads so EXU can stall rs1/rs2/rd hazards.

Parameters:
- LD_OUTST, 2, max outstanding loads (depth of the in-order load-rd FIFO); power of 2.
- WB_BUF_DEPTH, 2, depth of the load-return write buffer; power of 2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alu2wb_req_i  in  1  ALU/CSR write-back request; always accepted
- alu2wb_rd_addr_i  in  `YCR_MPRF_AWIDTH  ALU destination register
- alu2wb_rd_data_i  in  `YCR_XLEN  ALU result
- lsu2wb_ld_issue_i  in  1  load issued to memory (one-cycle pulse)
- lsu2wb_ld_rd_i  in  `YCR_MPRF_AWIDTH  destination register of the issued load
- wb2lsu_issue_rdy_o  out  1  load-rd FIFO not full; issue is legal only when high
- lsu2wb_ld_vd_i  in  1  load data valid
- lsu2wb_ld_data_i  in  `YCR_XLEN  load data
- wb2lsu_ld_rdy_o  out  1  write buffer not full
- exu2wb_rs1_addr_i  in  `YCR_MPRF_AWIDTH  decode-stage rs1
- exu2wb_rs2_addr_i  in  `YCR_MPRF_AWIDTH  decode-stage rs2
- exu2wb_rd_addr_i  in  `YCR_MPRF_AWIDTH  decode-stage rd
- wb2exu_hazard_o  out  1  stall request
- exu2mprf_w_req_o  out  1  MPRF write request
- exu2mprf_rd_addr_o  out  `YCR_MPRF_AWIDTH  MPRF write address
- exu2mprf_rd_data_o  out  `YCR_XLEN  MPRF write data
- wb_err_o  out  1  sticky: load data returned with no load outstanding

Behaviour:
- Reset: scoreboard cleared, both FIFOs empty, wb_err_o=0. Outputs: exu2mprf_w_req_o=0, addr/data 0, wb2lsu_issue_rdy_o=1, wb2lsu_ld_rdy_o=1, hazard 0.
- Issue: lsu2wb_ld_issue_i && wb2lsu_issue_rdy_o pushes lsu2wb_ld_rd_i into the load-rd FIFO.
  - If rd!=0, the scoreboard bit sets next cycle.
  - rd==0 is still pushed, so return ordering is preserved, but no scoreboard bit is set.
  - Issue with FIFO full is dropped.
- Return: lsu2wb_ld_vd_i && wb2lsu_ld_rdy_o pops the load-rd FIFO head and pushes {rd, data} into the write buffer.
  - Returns are in issue order.
  - If lsu2wb_ld_vd_i arrives with the load-rd FIFO empty: data discarded, wb_err_o set until reset.
- Write port mux (combinational), priority:
  - alu2wb_req_i set: output ALU addr/data (0-cycle latency).
  - Else, buffer non-empty: output buffer head and pop it.
  - Else: port idle.
  - exu2mprf_w_req_o = selected request AND addr!=0; addr/data are 0 when idle.
- Load latency: earliest MPRF write is 1 cycle after the return handshake. Each ALU-occupied cycle adds 1.
- Scoreboard clear: a bit clears in the cycle the buffered load for that rd is written to MPRF (registered, visible next cycle).
  - Set and clear of the same bit in one cycle: set wins.
- Hazard (combinational): wb2exu_hazard_o = (sb[rs1]&&rs1!=0) | (sb[rs2]&&rs2!=0) | (sb[rd]&&rd!=0).
  - The rd term blocks WAW, i.e. an ALU write overtaking a pending load.
  - EXU never issues an ALU write or load to a pending rd, so duplicate set/clear of one bit cannot occur.
- Full/empty:
  - Simultaneous push and pop on a full buffer is allowed only when the pop is decided in the same cycle. wb2lsu_ld_rdy_o is registered (full flag) and does not account for a same-cycle pop.
  - Pointers are log2(depth)+1 bits and wrap naturally.
- Reset mid-operation: all pending loads are forgotten. Any late return after reset sets wb_err_o.

Decomposition:
- Shared package: struct ycr_wb_entry_s {addr `YCR_MPRF_AWIDTH, data `YCR_XLEN}; the constants for the LD_OUTST and WB_BUF_DEPTH defaults.
- One sub-module, ycr_wb_fifo: parameterised width/depth synchronous FIFO with async active-low reset, push/pop/full/empty.
  - Instantiated twice: load-rd FIFO (width AWIDTH) and write buffer (width AWIDTH+XLEN).
- Scoreboard, mux and hazard logic stay in the top module.

Test Plan:
- Reset, then ALU write x5=0x1234 -> exu2mprf_w_req_o=1, addr=5, data=0x1234 in the same cycle; no hazard.
- Issue load to x7 -> next cycle, rs1=7 gives hazard=1. Return 0xDEAD -> write x7=0xDEAD one cycle later; hazard=0 the following cycle.
- Load return to x7 coincides with ALU write x3 for 3 consecutive cycles -> x3 writes first; x7 written in cycle 4; hazard held through cycle 4.
- Two loads issued (x8, x9) -> wb2lsu_issue_rdy_o=0. Returns A then B -> x8=A, x9=B in order; issue_rdy returns to 1.
- Load to x0 issued and returned -> no MPRF write request, no hazard at any point.
- lsu2wb_ld_vd_i with no load outstanding -> wb_err_o=1 and held; no MPRF write. Async reset pulse -> wb_err_o=0.
